// File: rtl/uart_loop_fifo_if.sv
// Loopback byte path between uart_rx/uart_tx and the loop FIFO.
// master = environment side (rx + tx status), slave = the FIFO block.
interface uart_loop_fifo_if #(
  parameter int D_WIDTH = 8
);
  logic [1:0]         rx_state;
  logic [D_WIDTH-1:0] rx_data;
  logic               tx_busy;
  logic               tx_en;
  logic [D_WIDTH-1:0] tx_data;

  modport master (output rx_state, rx_data, tx_busy, input tx_en, tx_data);
  modport slave  (input rx_state, rx_data, tx_busy, output tx_en, tx_data);
endinterface

// File: rtl/uart_loop_fifo.sv
// Circular byte FIFO between uart_rx and uart_tx with a one-byte-per-frame drain FSM.
// Optional: define UART_LOOP_FIFO_ECHO_CRLF_EN to follow every sent 0x0D with an inserted 0x0A.
module uart_loop_fifo #(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_loop_fifo_if.slave bus,
  input  logic            ovf_clr,
  output logic [AW:0]     count,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT_HI,
`ifdef UART_LOOP_FIFO_ECHO_CRLF_EN
    T_WAIT_LO,
    T_LF
`else
    T_WAIT_LO
`endif
  } tstate_t;

  localparam logic [1:0]  RX_IDLE  = 2'd0;
  localparam logic [1:0]  RX_STOP  = 2'd3;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
`ifdef UART_LOOP_FIFO_ECHO_CRLF_EN
  localparam logic [D_WIDTH-1:0] CR = D_WIDTH'(8'h0D);
  localparam logic [D_WIDTH-1:0] LF = D_WIDTH'(8'h0A);
`endif

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [1:0]         rx_prev;
  logic [AW:0]        count_nxt;
  logic               done, push, drop, pop;
  logic               tx_en_q;
  logic [D_WIDTH-1:0] tx_data_q;
  tstate_t            state;

  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;

  // STOP->IDLE edge marks a completed frame; rx_prev resets to IDLE so reset can't fake one.
  assign done = (rx_prev == RX_STOP) && (bus.rx_state == RX_IDLE);
  assign push = done && !full;
  assign drop = done && full;
  // Registered empty gates the pop, so a byte written this edge pops no earlier than the next.
  assign pop  = (state == T_IDLE) && !empty && !bus.tx_busy;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev  <= RX_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_prev <= bus.rx_state;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= bus.rx_data;
  end

  // tx_data only moves in T_IDLE/T_LF, so it is stable across the whole uart_tx frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= T_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      rd_ptr    <= '0;
    end else begin
      case (state)
        T_IDLE: begin
          if (pop) begin
            tx_data_q <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
            tx_en_q   <= 1'b1;
            state     <= T_WAIT_HI;
          end
        end
        T_WAIT_HI: begin
          tx_en_q <= 1'b0;
          if (bus.tx_busy) state <= T_WAIT_LO;
        end
        T_WAIT_LO: begin
          if (!bus.tx_busy) begin
`ifdef UART_LOOP_FIFO_ECHO_CRLF_EN
            state <= (tx_data_q == CR) ? T_LF : T_IDLE;
`else
            state <= T_IDLE;
`endif
          end
        end
`ifdef UART_LOOP_FIFO_ECHO_CRLF_EN
        T_LF: begin
          if (!bus.tx_busy) begin
            tx_data_q <= LF;
            tx_en_q   <= 1'b1;
            state     <= T_WAIT_HI;
          end
        end
`endif
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
- Byte buffer between uart_rx and uart_tx in the loopback path.
- Detects completed receive frames and pushes each byte into a circular FIFO.
- Drains the FIFO into uart_tx one byte at a time, holding data stable for the whole frame.
- Back-to-back RX frames are no longer lost while TX is busy.

Parameters:
- D_WIDTH, 8: byte width.
- DEPTH, 16: FIFO entries. Must be a power of 2, minimum 2.
- AW, 4: pointer width, log2(DEPTH).

Ports:
- clk  in  1  system clock (125 MHz)
- rst  in  1  synchronous, active-high reset
- rx_state  in  2  uart_rx state_o (IDLE=0, START=1, BUSY=2, STOP=3)
- rx_data  in  D_WIDTH  uart_rx rec_dout, passed unmodified; any bit reordering is done at top level
- tx_busy  in  1  uart_tx busy
- tx_en  out  1  one-cycle start pulse to uart_tx en
- tx_data  out  D_WIDTH  byte to uart_tx send_din; registered, held stable
- ovf_clr  in  1  clears overflow
- count  out  AW+1  current fill level, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky; set when a byte was dropped

Behaviour:
- Single clock domain. All state is updated on the posedge of clk.
- Reset (rst=1, synchronous) sets: tx_en=0, tx_data=0, count=0, empty=1, full=0, overflow=0. Read/write pointers go to 0 and the TX FSM goes to T_IDLE.
- Reset mid-frame: FIFO contents are discarded. A frame already started in uart_tx completes on its own (uart_tx ignores rst). After reset the block waits for tx_busy=0 before issuing a new tx_en.
- Frame-done detect: register rx_state into rx_prev. done = (rx_prev==3 && rx_state==0). Because rx_prev resets to 0, no false done after reset.
- Push on done:
  - If not full: write rx_data at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
  - If full: byte dropped, overflow<=1, pointers and count unchanged.
- TX FSM:
  - T_IDLE: if !empty && !tx_busy, then tx_data<=mem[rd_ptr], rd_ptr+1 (wrap), tx_en<=1, go T_WAIT_HI.
  - T_WAIT_HI: tx_en<=0. When tx_busy==1, go T_WAIT_LO.
  - T_WAIT_LO: when tx_busy==0, go T_IDLE. With ECHO_CRLF_EN, go T_LF instead if the byte just sent was 0x0D.
  - T_LF (only with ECHO_CRLF_EN): if !tx_busy, tx_data<=0x0A, tx_en<=1, go T_WAIT_HI. This path does not pop the FIFO.
- tx_data is changed only in T_IDLE and T_LF, so it stays stable throughout uart_tx START, when uart_tx latches it.
- Latency: done sampled at edge E (byte written). At edge E+1 the FSM in T_IDLE pops, and tx_en is high for the cycle after E+1. This gives 2 clocks from done detection to tx_en, assuming TX is idle.
- Simultaneous push and pop in the same cycle:
  - Both occur and count is unchanged.
  - Pop from a FIFO that is empty at that edge is never allowed; a byte pushed into an empty FIFO is first popped one cycle later.
  - Push when full with a simultaneous pop: the byte is still dropped, because full is evaluated before the pop.
- count arithmetic is AW+1 bits: +1 on push-only, -1 on pop-only. empty and full are registered and consistent with count.
- Overflow:
  - ovf_clr=1 clears overflow.
  - If ovf_clr and a drop occur in the same cycle, the set wins (overflow=1).

Optional Feature:
- Macro: UART_LOOP_FIFO_ECHO_CRLF_EN.
- Defined: every transmitted 0x0D is followed automatically by 0x0A, inserted via T_LF. The inserted 0x0A occupies no FIFO entry. FIFO bytes are held until the LF frame finishes.
- Undefined: bytes are forwarded verbatim. T_LF and its logic are absent.

Test Plan:
- Reset then one frame: after rst, rx_data=0x41 with rx_state 3->0 -> tx_en high exactly one cycle, 2 clocks after done; tx_data=0x41, held until tx_busy falls; count returns to 0.
- Burst while busy: 3 done events (0x11, 0x22, 0x33) during a single tx_busy=1 window -> count=3; bytes then sent in order 0x11, 0x22, 0x33; one tx_en per tx_busy low period.
- Overflow: 17 done events with tx_busy held 1 -> full=1, count=16, overflow=1; 17th byte absent from output. ovf_clr pulse -> overflow=0.
- Wrap-around: 40 bytes 0x00..0x27 pushed and popped interleaved -> output sequence identical to input; count never exceeds 16.
- Simultaneous push/pop and mid-frame reset: push coincident with a pop at count=5 -> count stays 5. rst asserted while tx_busy=1 -> count=0 and tx_en=0; no tx_en before tx_busy falls.
- CRLF (macro defined): input 0x0D then 0x42 -> output 0x0D, 0x0A, 0x42. Macro undefined: output 0x0D, 0x42.
